throw_entry_conditioner: RTL
============================

// Module: throw_entry_conditioner
// PURPOSE
//  Front-end for the bowling score keeper. Turns the raw "enter" push-button and
//  the 4 pin-count slide switches into the clean N[3:0] / UPD pair consumed by the
//  scoring controller. Synchronises, debounces, range-checks (0..10) and emits
//  one UPD pulse per accepted press, with N held stable until the next accepted press.
// PARAMETERS
//  DEB_CYCLES  16  consecutive stable cycles before the debounced button level changes (board build: 500000)
//  HOLDOFF     8   idle cycles enforced after button release before the next press is armed
// PORTS
//  clock    in   1  system clock; all flops posedge
//  reset    in   1  asynchronous, active-high; clears all state
//  btn_raw  in   1  raw enter button, asynchronous, bouncy, 1 = pressed
//  sw_raw   in   4  raw pin-count switches, asynchronous
//  Done     in   1  game finished (from controller); blocks new UPD pulses
//  N        out  4  accepted pins knocked down, registered, stable between accepted presses
//  UPD      out  1  update pulse, exactly one clock wide, registered
//  err      out  1  last press had sw > 10 and was rejected; sticky until next accepted press
// BEHAVIOUR
//  Reset: N=0, UPD=0, err=0, sync flops=0, btn_db=0, deb counter=0, hold counter=0, state=S_IDLE.
//  Sync: btn_raw and sw_raw each pass through 2 flops (btn_s, sw_s); nothing else reads raw inputs.
//  Debounce: counter clears whenever btn_s==btn_db; else increments; when it reaches DEB_CYCLES,
//   btn_db <= btn_s and counter clears. Counter width $clog2(DEB_CYCLES+1), never wraps.
//  rise = btn_db & ~btn_db_q (1-cycle edge detect).
//  FSM:
//   S_IDLE:    on rise -> S_PRESSED; in the same edge:
//              Done=1        -> no UPD, N/err unchanged
//              sw_s<=10      -> N<=sw_s, UPD<=1, err<=0
//              sw_s>10       -> err<=1, N unchanged, no UPD
//   S_PRESSED: btn_db==0 -> S_HOLD, hold counter<=0
//   S_HOLD:    counter increments; at HOLDOFF-1 -> S_IDLE. rise here is ignored (no UPD, no err).
//   Illegal encoding -> S_IDLE.
//  UPD clears the cycle after it is set: never high two consecutive cycles.
//  Latency: edge 0 = first edge sampling btn_raw=1 with no further bounce; btn_db rises at edge
//   DEB_CYCLES+1; UPD is high from edge DEB_CYCLES+3 to DEB_CYCLES+4 (one full cycle, so the
//   negedge-sampling controller always sees it).
//  N is sampled from sw_s at the same edge UPD is set; switch changes afterwards do not
//   affect N until the next accepted press (scoring adds N over several cycles).
//  Bounce shorter than DEB_CYCLES on press or release produces no extra pulse.
//  Min spacing between UPD pulses: press debounce + release debounce + HOLDOFF cycles.
//  Done rising while a press is in flight: a press not yet at S_IDLE->S_PRESSED produces no UPD.
//  Reset mid-press: everything clears asynchronously; a button still held when reset drops
//   is seen as a new press after DEB_CYCLES and is processed normally.
//  sw_s = 10 is legal (strike); 11..15 rejected.
// STRUCTURE
//  Shared package/include: MAX_PINS = 4'd10, FSM state encodings (S_IDLE, S_PRESSED, S_HOLD).
//  Sub-module: debounce_filter (sync + stable-count filter, params DEB_CYCLES), one instance for
//   btn_raw; switches use plain 2-flop sync only. FSM, range check, output regs live in the top.
// TESTING
//  1 clean press, sw=7, DEB_CYCLES=16 -> one UPD pulse at edge 19 from press, N=7, err=0.
//  2 press with 5 bounces of 3 cycles each, sw=10 -> exactly one UPD, N=10; release bounce -> no UPD.
//  3 sw=12, press -> no UPD, err=1, N keeps previous value; then sw=3, press -> UPD, N=3, err=0.
//  4 change sw 4->9 one cycle after UPD -> N stays 4 until next press.
//  5 Done=1, press with sw=5 -> no UPD, N unchanged; Done=0, press -> UPD, N=5.
//  6 assert reset while button held mid-debounce -> all outputs 0 at once; release reset with
//    button held -> one UPD after DEB_CYCLES+3; second press within HOLDOFF -> ignored.

Source files
------------

// File: rtl/throw_entry_conditioner_pkg.sv
// Shared constants and FSM encodings for the throw entry conditioner.
package throw_entry_conditioner_pkg;

  localparam logic [3:0] MAX_PINS = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  // A pin count is legal from 0 up to and including a strike.
  function automatic logic pins_ok(input logic [3:0] sw);
    return (sw <= MAX_PINS);
  endfunction

endpackage

// File: rtl/throw_entry_conditioner_if.sv
// Signal bundle between the raw board inputs / scoring controller and the conditioner.
interface throw_entry_conditioner_if;
  import throw_entry_conditioner_pkg::*;

  // UPD is a one-clock strobe with no ready/back-pressure: the controller must
  // take N on the cycle UPD is high; N stays valid until the next UPD.
  logic       btn_raw;
  logic [3:0] sw_raw;
  logic       Done;
  logic [3:0] N;
  logic       UPD;
  logic       err;
  state_t     state_dbg;

  modport master (output btn_raw, sw_raw, Done, input N, UPD, err, state_dbg);
  modport slave  (input btn_raw, sw_raw, Done, output N, UPD, err, state_dbg);

endinterface

// File: rtl/throw_entry_conditioner_debounce_filter.sv
// Two-flop synchroniser plus stable-count debounce; emits the debounced level and a registered rise strobe.
module throw_entry_conditioner_debounce_filter #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      rise <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      db_q <= db;
      rise <= db & ~db_q;
      // Any return to the current level restarts the stability count.
      if (sync == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/throw_entry_conditioner.sv
// Turns a bouncy enter button and pin switches into a clean N / UPD pair for the score keeper.
module throw_entry_conditioner
  import throw_entry_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int HOLDOFF    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  throw_entry_conditioner_if.slave  bus
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  logic          btn_db;
  logic          rise;
  logic [3:0]    sw_meta;
  logic [3:0]    sw_s;
  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [3:0]    n_q, n_n;
  logic          upd_q, upd_n;
  logic          err_q, err_n;

  throw_entry_conditioner_debounce_filter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_filter (
    .clock (clock),
    .reset (reset),
    .raw   (bus.btn_raw),
    .db    (btn_db),
    .rise  (rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_s     <= '0;
      state    <= S_IDLE;
      hold_cnt <= '0;
      n_q      <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sw_meta  <= bus.sw_raw;
      sw_s     <= sw_meta;
      state    <= state_n;
      hold_cnt <= hold_n;
      n_q      <= n_n;
      upd_q    <= upd_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    n_n     = n_q;
    upd_n   = 1'b0;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        // A press is consumed even when Done blocks it, so it cannot fire later.
        if (rise) begin
          state_n = S_PRESSED;
          if (!bus.Done) begin
            if (pins_ok(sw_s)) begin
              n_n   = sw_s;
              upd_n = 1'b1;
              err_n = 1'b0;
            end else begin
              err_n = 1'b1;
            end
          end
        end
      end
      S_PRESSED: begin
        if (!btn_db) begin
          state_n = S_HOLD;
          hold_n  = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = S_IDLE;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.N         = n_q;
  assign bus.UPD       = upd_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;

endmodule
